// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared widths, fetch FSM states (FAULT only with FETCH_BOUNDS_CHECK_EN) for the instruction fetch sequencer
package cpu_fetch_pkg;
  localparam int ADDR_W      = 24;
  localparam int INSTR_W     = 24;
  localparam int BYTE_W      = 8;
  localparam int INSTR_BYTES = 3;
  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, CAP, VALID
`ifdef FETCH_BOUNDS_CHECK_EN
    , FAULT
`endif
  } fetch_state_t;
endpackage

// File: rtl/instr_byte_packer.sv
// instr_byte_packer: three-slot byte register, slot 0 is the most significant byte of the 24-bit word
module instr_byte_packer
  import cpu_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               we,
  input  logic [1:0]         idx,
  input  logic [BYTE_W-1:0]  din,
  output logic [INSTR_W-1:0] word
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      word <= '0;
    else if (clr)
      word <= '0;
    else if (we)
      for (int i = 0; i < INSTR_BYTES; i++)
        if (idx == 2'(i)) word[INSTR_W-1-BYTE_W*i -: BYTE_W] <= din;
endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: 3-byte big-endian instruction fetch FSM owning the PC with branch redirect; FETCH_BOUNDS_CHECK_EN adds fetch_fault
module instr_fetch_sequencer
  import cpu_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       MEM_BYTES    = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_enable,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [BYTE_W-1:0]  mem_rd_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic               fetch_fault
`endif
);
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);
  fetch_state_t state;
  logic         pk_we;
  logic [1:0]   pk_idx;
  function automatic logic rd_ok(input logic [ADDR_W-1:0] a);
    return !CHECK || (({1'b0, a} + 25'd2) < 25'(MEM_BYTES));
  endfunction
  always_comb begin
    pk_we  = (state == RD1 || state == RD2 || state == CAP) && !branch_valid;
    pk_idx = state == RD1 ? 2'd0 : state == RD2 ? 2'd1 : 2'd2;
  end
  instr_byte_packer u_packer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (branch_valid),
    .we   (pk_we),
    .idx  (pk_idx),
    .din  (mem_rd_data),
    .word (instruction)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else if (branch_valid) begin
      pc          <= branch_target;
      state       <= fetch_enable ? RD0 : IDLE;
      mem_addr    <= branch_target;
      mem_rd_en   <= fetch_enable && rd_ok(branch_target);
      instr_valid <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:
          if (fetch_enable) begin
            state     <= RD0;
            mem_addr  <= pc;
            mem_rd_en <= rd_ok(pc);
          end
        RD0:
`ifdef FETCH_BOUNDS_CHECK_EN
          if (!rd_ok(pc)) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
          end else
`endif
          begin
            state    <= RD1;
            mem_addr <= pc + ADDR_W'(1);
          end
        RD1: begin
          state    <= RD2;
          mem_addr <= pc + ADDR_W'(2);
        end
        RD2: begin
          state     <= CAP;
          mem_rd_en <= 1'b0;
        end
        CAP: begin
          state       <= VALID;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
        end
        VALID:
          if (instr_ready) begin
            pc          <= pc + STEP;
            instr_valid <= 1'b0;
            state       <= fetch_enable ? RD0 : IDLE;
            mem_addr    <= pc + STEP;
            mem_rd_en   <= fetch_enable && rd_ok(pc + STEP);
          end
        default: state <= state;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed self-checking bench for instr_fetch_sequencer with a 128-byte synchronous memory model
module tb_instr_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        branch_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic [23:0] branch_target = '0;
  logic [7:0]  mem_rd_data = '0;
  logic [23:0] mem_addr, instruction, instr_pc, pc;
  logic        mem_rd_en, instr_valid;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fetch_fault;
`endif
  logic [7:0]  mem [128];
  int          n_chk = 0;
  int          n_fail = 0;
  instr_fetch_sequencer #(.RESET_VECTOR(24'd0), .MEM_BYTES(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_enable (fetch_enable),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .pc           (pc)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .fetch_fault  (fetch_fault)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[6:0]];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    fetch_enable = 1'b0;
    branch_valid = 1'b0;
    instr_ready = 1'b0;
    branch_target = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 50) begin
      tick;
      n++;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_chk++;
    if ({mem_rd_en, instr_valid, mem_addr, instruction, instr_pc, pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_en=%b valid=%b addr=%h instr=%h ipc=%h pc=%h, want all 0", mem_rd_en, instr_valid, mem_addr, instruction, instr_pc, pc);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++;
      if ({mem_rd_en, instr_valid, pc} !== {1'b0, 1'b0, 24'd0}) begin
        n_fail++;
        $display("FAIL idle_hold: rd_en=%b valid=%b pc=%h, want 0 0 000000", mem_rd_en, instr_valid, pc);
      end
    end
  endtask
  task automatic test_basic;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    wait_valid(n);
    n_chk++;
    if (n !== 5) begin n_fail++; $display("FAIL first_latency: got %0d cycles, want 5", n); end
    n_chk++;
    if ({instruction, instr_pc, pc} !== {24'h010203, 24'd0, 24'd0}) begin
      n_fail++;
      $display("FAIL first_word: instr=%h ipc=%h pc=%h, want 010203 000000 000000", instruction, instr_pc, pc);
    end
    tick;
    n_chk++;
    if ({mem_rd_en, mem_addr, pc, instr_valid} !== {1'b1, 24'd3, 24'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL accept_rd0: rd_en=%b addr=%h pc=%h valid=%b, want 1 000003 000003 0", mem_rd_en, mem_addr, pc, instr_valid);
    end
    for (int i = 4; i <= 5; i++) begin
      tick;
      n_chk++;
      if ({mem_rd_en, mem_addr} !== {1'b1, 24'(i)}) begin
        n_fail++;
        $display("FAIL rd_addr: rd_en=%b addr=%h, want 1 %h", mem_rd_en, mem_addr, 24'(i));
      end
    end
    tick;
    n_chk++;
    if ({mem_rd_en, instr_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL cap_state: rd_en=%b valid=%b, want 0 0", mem_rd_en, instr_valid);
    end
    tick;
    n_chk++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 24'h040506, 24'd3}) begin
      n_fail++;
      $display("FAIL second_word: valid=%b instr=%h ipc=%h, want 1 040506 000003", instr_valid, instruction, instr_pc);
    end
  endtask
  task automatic test_hold;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    wait_valid(n);
    n_chk++;
    if (n !== 5) begin n_fail++; $display("FAIL hold_latency: got %0d cycles, want 5", n); end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({instr_valid, mem_rd_en, instruction, instr_pc, pc} !== {1'b1, 1'b0, 24'h010203, 24'd0, 24'd0}) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b rd_en=%b instr=%h ipc=%h pc=%h, want 1 0 010203 000000 000000", instr_valid, mem_rd_en, instruction, instr_pc, pc);
      end
      tick;
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    n_chk++;
    if ({pc, instr_valid, mem_rd_en, mem_addr} !== {24'd3, 1'b0, 1'b1, 24'd3}) begin
      n_fail++;
      $display("FAIL hold_accept: pc=%h valid=%b rd_en=%b addr=%h, want 000003 0 1 000003", pc, instr_valid, mem_rd_en, mem_addr);
    end
  endtask
  task automatic test_branch_rd2;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    while (!(mem_rd_en && mem_addr == 24'd2) && n < 20) begin
      tick;
      n++;
    end
    n_chk++;
    if (mem_addr !== 24'd2) begin n_fail++; $display("FAIL reach_rd2: addr=%h, want 000002", mem_addr); end
    branch_valid = 1'b1;
    branch_target = 24'd30;
    tick;
    branch_valid = 1'b0;
    n_chk++;
    if ({pc, instr_valid, mem_rd_en, mem_addr} !== {24'd30, 1'b0, 1'b1, 24'd30}) begin
      n_fail++;
      $display("FAIL branch_rd2: pc=%h valid=%b rd_en=%b addr=%h, want 00001e 0 1 00001e", pc, instr_valid, mem_rd_en, mem_addr);
    end
    wait_valid(n);
    n_chk++;
    if (n !== 4) begin n_fail++; $display("FAIL branch_latency: got %0d cycles, want 4", n); end
    n_chk++;
    if ({instruction, instr_pc} !== {24'h1f2021, 24'd30}) begin
      n_fail++;
      $display("FAIL branch_word: instr=%h ipc=%h, want 1f2021 00001e", instruction, instr_pc);
    end
  endtask
  task automatic test_branch_accept;
    int n;
    branch_valid = 1'b1;
    branch_target = 24'd60;
    tick;
    branch_valid = 1'b0;
    n_chk++;
    if ({pc, instr_valid, mem_rd_en, mem_addr} !== {24'd60, 1'b0, 1'b1, 24'd60}) begin
      n_fail++;
      $display("FAIL branch_accept: pc=%h valid=%b rd_en=%b addr=%h, want 00003c 0 1 00003c", pc, instr_valid, mem_rd_en, mem_addr);
    end
    wait_valid(n);
    n_chk++;
    if ({n[7:0], instruction, instr_pc} !== {8'd4, 24'h3d3e3f, 24'd60}) begin
      n_fail++;
      $display("FAIL branch_accept_word: cycles=%0d instr=%h ipc=%h, want 4 3d3e3f 00003c", n, instruction, instr_pc);
    end
  endtask
  task automatic test_stop_midfetch;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    tick;
    tick;
    fetch_enable = 1'b0;
    wait_valid(n);
    n_chk++;
    if ({n[7:0], instruction} !== {8'd3, 24'h010203}) begin
      n_fail++;
      $display("FAIL stop_complete: cycles=%0d instr=%h, want 3 010203", n, instruction);
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({pc, mem_rd_en, instr_valid} !== {24'd3, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stop_idle: pc=%h rd_en=%b valid=%b, want 000003 0 0", pc, mem_rd_en, instr_valid);
      end
      tick;
    end
    branch_valid = 1'b1;
    branch_target = 24'd90;
    tick;
    branch_valid = 1'b0;
    tick;
    n_chk++;
    if ({pc, mem_rd_en, instr_valid} !== {24'd90, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_branch: pc=%h rd_en=%b valid=%b, want 00005a 0 0", pc, mem_rd_en, instr_valid);
    end
    fetch_enable = 1'b1;
    tick;
    n_chk++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 24'd90}) begin
      n_fail++;
      $display("FAIL idle_resume: rd_en=%b addr=%h, want 1 00005a", mem_rd_en, mem_addr);
    end
  endtask
  task automatic test_wrap;
    int n;
    logic [23:0] exp_addr [3];
    exp_addr[0] = 24'hfffffe;
    exp_addr[1] = 24'hffffff;
    exp_addr[2] = 24'h000000;
    do_reset;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    branch_valid = 1'b1;
    branch_target = 24'hfffffe;
    for (int i = 0; i < 3; i++) begin
      tick;
      branch_valid = 1'b0;
      n_chk++;
      if ({mem_rd_en, mem_addr} !== {1'b1, exp_addr[i]}) begin
        n_fail++;
        $display("FAIL wrap_addr: rd_en=%b addr=%h, want 1 %h", mem_rd_en, mem_addr, exp_addr[i]);
      end
    end
    wait_valid(n);
    n_chk++;
    if ({n[7:0], instruction, instr_pc} !== {8'd2, 24'h7f8001, 24'hfffffe}) begin
      n_fail++;
      $display("FAIL wrap_word: cycles=%0d instr=%h ipc=%h, want 2 7f8001 fffffe", n, instruction, instr_pc);
    end
    tick;
    n_chk++;
    if ({pc, mem_addr} !== {24'd1, 24'd1}) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h addr=%h, want 000001 000001", pc, mem_addr);
    end
  endtask
  task automatic test_async_reset;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    wait_valid(n);
    tick;
    tick;
    n_chk++;
    if ({mem_rd_en, mem_addr, pc, instruction} !== {1'b1, 24'd4, 24'd3, 24'h010203}) begin
      n_fail++;
      $display("FAIL pre_async_rd1: rd_en=%b addr=%h pc=%h instr=%h, want 1 000004 000003 010203", mem_rd_en, mem_addr, pc, instruction);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_rd_en, instr_valid, mem_addr, instruction, instr_pc, pc} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rd_en=%b valid=%b addr=%h instr=%h ipc=%h pc=%h, want all 0", mem_rd_en, instr_valid, mem_addr, instruction, instr_pc, pc);
    end
    #3;
    rst_n = 1'b1;
    tick;
    n_chk++;
    if ({mem_rd_en, mem_addr, pc} !== {1'b1, 24'd0, 24'd0}) begin
      n_fail++;
      $display("FAIL async_restart: rd_en=%b addr=%h pc=%h, want 1 000000 000000", mem_rd_en, mem_addr, pc);
    end
  endtask
`ifdef FETCH_BOUNDS_CHECK_EN
  task automatic test_bounds;
    int n;
    do_reset;
    fetch_enable = 1'b1;
    instr_ready = 1'b1;
    branch_valid = 1'b1;
    branch_target = 24'd126;
    tick;
    branch_valid = 1'b0;
    n_chk++;
    if ({fetch_fault, mem_rd_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL bounds_rd0: fault=%b rd_en=%b, want 0 0", fetch_fault, mem_rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_chk++;
      if ({fetch_fault, mem_rd_en, instr_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL bounds_fault: fault=%b rd_en=%b valid=%b, want 1 0 0", fetch_fault, mem_rd_en, instr_valid);
      end
    end
    branch_valid = 1'b1;
    branch_target = 24'd0;
    tick;
    branch_valid = 1'b0;
    n_chk++;
    if ({fetch_fault, mem_rd_en, mem_addr} !== {1'b0, 1'b1, 24'd0}) begin
      n_fail++;
      $display("FAIL bounds_recover: fault=%b rd_en=%b addr=%h, want 0 1 000000", fetch_fault, mem_rd_en, mem_addr);
    end
    wait_valid(n);
    n_chk++;
    if ({n[7:0], instruction} !== {8'd4, 24'h010203}) begin
      n_fail++;
      $display("FAIL bounds_word: cycles=%0d instr=%h, want 4 010203", n, instruction);
    end
  endtask
`endif
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
    test_reset;
    test_basic;
    test_hold;
    test_branch_rd2;
    test_branch_accept;
    test_stop_midfetch;
`ifdef FETCH_BOUNDS_CHECK_EN
    test_bounds;
`else
    test_wrap;
`endif
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
